// File: rtl/alusrc_ctrl_fsm_pkg.sv
// Shared encodings for the multicycle control sequencer: states, opcodes, functs,
// ALU operation codes, operand-select codes and PC source codes.
package alusrc_ctrl_fsm_pkg;

  localparam logic [3:0] S_RESET  = 4'd0;
  localparam logic [3:0] S_FETCH  = 4'd1;
  localparam logic [3:0] S_DECODE = 4'd2;
  localparam logic [3:0] S_EXEC_R = 4'd3;
  localparam logic [3:0] S_WB_R   = 4'd4;
  localparam logic [3:0] S_EXEC_I = 4'd5;
  localparam logic [3:0] S_WB_I   = 4'd6;
  localparam logic [3:0] S_ADDR   = 4'd7;
  localparam logic [3:0] S_MEM_RD = 4'd8;
  localparam logic [3:0] S_WB_LW  = 4'd9;
  localparam logic [3:0] S_MEM_WR = 4'd10;
  localparam logic [3:0] S_BRANCH = 4'd11;
  localparam logic [3:0] S_JUMP   = 4'd12;
  localparam logic [3:0] S_HALT   = 4'd13;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_SLT = 6'h2A;

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_AND  = 3'd2;
  localparam logic [2:0] ALU_OR   = 3'd3;
  localparam logic [2:0] ALU_SLT  = 3'd4;
  localparam logic [2:0] ALU_PASS = 3'd7;

  localparam logic [1:0] SEL_B       = 2'd0;
  localparam logic [1:0] SEL_4       = 2'd1;
  localparam logic [1:0] SEL_IMM     = 2'd2;
  localparam logic [1:0] SEL_IMM_SH2 = 2'd3;

  localparam logic [1:0] PC_ALU    = 2'd0;
  localparam logic [1:0] PC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;

  typedef struct packed {
    logic       seletor_alua;
    logic [1:0] seletor_alub;
    logic [2:0] alu_op;
    logic [1:0] pc_src;
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_wr;
    logic       ir_write;
    logic       ab_write;
    logic       aluout_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
  } ctrl_t;

endpackage

// File: rtl/alusrc_ctrl_fsm_if.sv
// Instruction-register inputs and datapath control outputs of the sequencer.
interface alusrc_ctrl_fsm_if;

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       seletor_alua;
  logic [1:0] seletor_alub;
  logic [2:0] alu_op;
  logic [1:0] pc_src;
  logic       pc_write;
  logic       pc_write_cond;
  logic       iord;
  logic       mem_wr;
  logic       ir_write;
  logic       ab_write;
  logic       aluout_write;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       illegal;
  logic [3:0] state_o;

  modport master (
    input  opcode, funct, zero,
    output seletor_alua, seletor_alub, alu_op, pc_src, pc_write, pc_write_cond,
           iord, mem_wr, ir_write, ab_write, aluout_write, reg_write, reg_dst,
           mem_to_reg, illegal, state_o
  );

  modport slave (
    output opcode, funct, zero,
    input  seletor_alua, seletor_alub, alu_op, pc_src, pc_write, pc_write_cond,
           iord, mem_wr, ir_write, ab_write, aluout_write, reg_write, reg_dst,
           mem_to_reg, illegal, state_o
  );

endinterface

// File: rtl/alusrc_ctrl_fsm_alu_funct_dec.sv
// R-type funct field to ALU operation; unknown functs default to add and flag illegal.
module alu_funct_dec
  import alusrc_ctrl_fsm_pkg::*;
(
  input  logic [5:0] funct_i,
  output logic [2:0] alu_op_o,
  output logic       illegal_o
);

  always_comb begin
    alu_op_o  = ALU_ADD;
    illegal_o = 1'b0;
    case (funct_i)
      F_ADD:   alu_op_o = ALU_ADD;
      F_SUB:   alu_op_o = ALU_SUB;
      F_AND:   alu_op_o = ALU_AND;
      F_OR:    alu_op_o = ALU_OR;
      F_SLT:   alu_op_o = ALU_SLT;
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/alusrc_ctrl_fsm.sv
// Multicycle Moore control sequencer driving ALU operand selects, alu_op and
// datapath write enables for R-type, addi, lw, sw, beq and j.
//   state    | meaning
//   S_RESET  | idle after reset, all outputs low
//   S_FETCH  | memory read at PC, PC+4; IR/PC load on last wait cycle
//   S_DECODE | load A/B, precompute branch target into ALUOut
//   S_EXEC_R | R-type ALU operation
//   S_WB_R   | write ALUOut to rd
//   S_EXEC_I | addi: A + imm
//   S_WB_I   | write ALUOut to rt
//   S_ADDR   | lw/sw effective address
//   S_MEM_RD | data read at ALUOut, held MEM_WAIT+1 cycles
//   S_WB_LW  | write MDR to rt
//   S_MEM_WR | data write at ALUOut, held MEM_WAIT+1 cycles
//   S_BRANCH | compare A-B, PC <- ALUOut if zero
//   S_JUMP   | PC <- jump target
//   S_HALT   | illegal instruction, absorbing until reset
module alusrc_ctrl_fsm
  import alusrc_ctrl_fsm_pkg::*;
#(
  parameter int MEM_WAIT = 2
) (
  input  logic                clk,
  input  logic                reset,
  alusrc_ctrl_fsm_if.master   bus
);

  localparam logic [2:0] WAIT_MAX = 3'(MEM_WAIT);

  logic [3:0] state_q, state_d;
  logic [2:0] wait_cnt_q, wait_cnt_d;
  logic       illegal_q, illegal_d;
  logic       wait_done;
  logic [2:0] r_alu_op;
  logic       r_illegal;
  ctrl_t      ctrl;

  // zero only gates the PC load inside the datapath; the sequencer never reads it.
  logic       zero_unused;
  assign zero_unused = bus.zero;

  alu_funct_dec u_funct_dec (
    .funct_i   (bus.funct),
    .alu_op_o  (r_alu_op),
    .illegal_o (r_illegal)
  );

  assign wait_done = (wait_cnt_q == WAIT_MAX);

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    ctrl      = '0;
    case (state_q)
      S_RESET: state_d = S_FETCH;
      S_FETCH: begin
        ctrl.seletor_alub = SEL_4;
        ctrl.alu_op       = ALU_ADD;
        ctrl.pc_src       = PC_ALU;
        if (wait_done) begin
          ctrl.ir_write = 1'b1;
          ctrl.pc_write = 1'b1;
          state_d       = S_DECODE;
        end
      end
      S_DECODE: begin
        ctrl.ab_write     = 1'b1;
        ctrl.aluout_write = 1'b1;
        ctrl.seletor_alub = SEL_IMM_SH2;
        ctrl.alu_op       = ALU_ADD;
        case (bus.opcode)
          OP_RTYPE:     state_d = S_EXEC_R;
          OP_ADDI:      state_d = S_EXEC_I;
          OP_LW, OP_SW: state_d = S_ADDR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          default: begin
            illegal_d = 1'b1;
            state_d   = S_HALT;
          end
        endcase
      end
      S_EXEC_R: begin
        ctrl.seletor_alua = 1'b1;
        ctrl.seletor_alub = SEL_B;
        ctrl.alu_op       = r_alu_op;
        ctrl.aluout_write = 1'b1;
        if (r_illegal) begin
          illegal_d = 1'b1;
          state_d   = S_HALT;
        end else begin
          state_d = S_WB_R;
        end
      end
      S_WB_R: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
        state_d        = S_FETCH;
      end
      S_EXEC_I, S_ADDR: begin
        ctrl.seletor_alua = 1'b1;
        ctrl.seletor_alub = SEL_IMM;
        ctrl.alu_op       = ALU_ADD;
        ctrl.aluout_write = 1'b1;
        if (state_q == S_EXEC_I) state_d = S_WB_I;
        else if (bus.opcode == OP_SW) state_d = S_MEM_WR;
        else state_d = S_MEM_RD;
      end
      S_WB_I: begin
        ctrl.reg_write = 1'b1;
        state_d        = S_FETCH;
      end
      S_MEM_RD: begin
        ctrl.iord = 1'b1;
        if (wait_done) state_d = S_WB_LW;
      end
      S_WB_LW: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        state_d         = S_FETCH;
      end
      S_MEM_WR: begin
        ctrl.iord   = 1'b1;
        ctrl.mem_wr = 1'b1;
        if (wait_done) state_d = S_FETCH;
      end
      S_BRANCH: begin
        ctrl.seletor_alua  = 1'b1;
        ctrl.seletor_alub  = SEL_B;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_src        = PC_ALUOUT;
        ctrl.pc_write_cond = 1'b1;
        state_d            = S_FETCH;
      end
      S_JUMP: begin
        ctrl.pc_src   = PC_JUMP;
        ctrl.pc_write = 1'b1;
        state_d       = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_RESET;
    endcase
  end

  always_comb begin
    if (state_d != state_q) wait_cnt_d = 3'd0;
    else if (!wait_done)    wait_cnt_d = wait_cnt_q + 3'd1;
    else                    wait_cnt_d = wait_cnt_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_RESET;
      wait_cnt_q <= 3'd0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      illegal_q  <= illegal_d;
    end
  end

  assign bus.seletor_alua  = ctrl.seletor_alua;
  assign bus.seletor_alub  = ctrl.seletor_alub;
  assign bus.alu_op        = ctrl.alu_op;
  assign bus.pc_src        = ctrl.pc_src;
  assign bus.pc_write      = ctrl.pc_write;
  assign bus.pc_write_cond = ctrl.pc_write_cond;
  assign bus.iord          = ctrl.iord;
  assign bus.mem_wr        = ctrl.mem_wr;
  assign bus.ir_write      = ctrl.ir_write;
  assign bus.ab_write      = ctrl.ab_write;
  assign bus.aluout_write  = ctrl.aluout_write;
  assign bus.reg_write     = ctrl.reg_write;
  assign bus.reg_dst       = ctrl.reg_dst;
  assign bus.mem_to_reg    = ctrl.mem_to_reg;
  assign bus.illegal       = illegal_q;
  assign bus.state_o       = state_q;

endmodule

// File: tb/tb_alusrc_ctrl_fsm.sv
// Directed bench for alusrc_ctrl_fsm: per-cycle expected control words are queued
// per instruction and compared against the DUT on each falling edge.
module tb_alusrc_ctrl_fsm;
  import alusrc_ctrl_fsm_pkg::*;

  localparam int MW = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  alusrc_ctrl_fsm_if bus ();

  alusrc_ctrl_fsm #(.MEM_WAIT(MW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [3:0] st;
    logic       ill;
    logic       alua;
    logic [1:0] alub;
    logic [2:0] aluop;
    logic [1:0] pcsrc;
    logic       pcw, pcwc, iord, memwr, irw, abw, aluoutw, regw, regdst, memtoreg;
  } obs_t;

  obs_t  exp_q[$];
  string tag_q[$];
  int    checks = 0;
  int    errors = 0;

  function automatic obs_t sample();
    obs_t o;
    o.st       = bus.state_o;
    o.ill      = bus.illegal;
    o.alua     = bus.seletor_alua;
    o.alub     = bus.seletor_alub;
    o.aluop    = bus.alu_op;
    o.pcsrc    = bus.pc_src;
    o.pcw      = bus.pc_write;
    o.pcwc     = bus.pc_write_cond;
    o.iord     = bus.iord;
    o.memwr    = bus.mem_wr;
    o.irw      = bus.ir_write;
    o.abw      = bus.ab_write;
    o.aluoutw  = bus.aluout_write;
    o.regw     = bus.reg_write;
    o.regdst   = bus.reg_dst;
    o.memtoreg = bus.mem_to_reg;
    return o;
  endfunction

  function automatic obs_t mk(input logic [3:0] st, input logic ill);
    obs_t o = '0;
    o.st  = st;
    o.ill = ill;
    return o;
  endfunction

  task automatic chk(input obs_t got, input obs_t exp, input string tag);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic push(input obs_t o, input string tag);
    exp_q.push_back(o);
    tag_q.push_back(tag);
  endtask

  task automatic push_fetch(input string n);
    obs_t o;
    for (int i = 0; i <= MW; i++) begin
      o = mk(S_FETCH, 1'b0);
      o.alub = SEL_4;
      if (i == MW) begin
        o.irw = 1'b1;
        o.pcw = 1'b1;
      end
      push(o, {n, ".FETCH"});
    end
  endtask

  task automatic push_decode(input string n);
    obs_t o = mk(S_DECODE, 1'b0);
    o.alub    = SEL_IMM_SH2;
    o.abw     = 1'b1;
    o.aluoutw = 1'b1;
    push(o, {n, ".DECODE"});
  endtask

  task automatic push_imm(input logic [3:0] st, input string n);
    obs_t o = mk(st, 1'b0);
    o.alua    = 1'b1;
    o.alub    = SEL_IMM;
    o.aluoutw = 1'b1;
    push(o, n);
  endtask

  task automatic drain();
    obs_t  e;
    string t;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      chk(sample(), e, t);
    end
  endtask

  task automatic run_r(input logic [5:0] fn, input logic [2:0] op_exp, input string n);
    obs_t o;
    bus.opcode = OP_RTYPE;
    bus.funct  = fn;
    push_fetch(n);
    push_decode(n);
    o = mk(S_EXEC_R, 1'b0);
    o.alua = 1'b1; o.alub = SEL_B; o.aluop = op_exp; o.aluoutw = 1'b1;
    push(o, {n, ".EXEC_R"});
    o = mk(S_WB_R, 1'b0);
    o.regw = 1'b1; o.regdst = 1'b1;
    push(o, {n, ".WB_R"});
    drain();
  endtask

  task automatic run_addi();
    obs_t o;
    bus.opcode = OP_ADDI;
    push_fetch("addi");
    push_decode("addi");
    push_imm(S_EXEC_I, "addi.EXEC_I");
    o = mk(S_WB_I, 1'b0);
    o.regw = 1'b1;
    push(o, "addi.WB_I");
    drain();
  endtask

  task automatic run_lw();
    obs_t o;
    bus.opcode = OP_LW;
    push_fetch("lw");
    push_decode("lw");
    push_imm(S_ADDR, "lw.ADDR");
    for (int i = 0; i <= MW; i++) begin
      o = mk(S_MEM_RD, 1'b0);
      o.iord = 1'b1;
      push(o, "lw.MEM_RD");
    end
    o = mk(S_WB_LW, 1'b0);
    o.regw = 1'b1; o.memtoreg = 1'b1;
    push(o, "lw.WB_LW");
    drain();
  endtask

  task automatic run_sw(input int wr_cycles);
    obs_t o;
    bus.opcode = OP_SW;
    push_fetch("sw");
    push_decode("sw");
    push_imm(S_ADDR, "sw.ADDR");
    for (int i = 0; i < wr_cycles; i++) begin
      o = mk(S_MEM_WR, 1'b0);
      o.iord = 1'b1; o.memwr = 1'b1;
      push(o, "sw.MEM_WR");
    end
    drain();
  endtask

  task automatic run_beq(input logic z);
    obs_t o;
    bus.opcode = OP_BEQ;
    bus.zero   = z;
    push_fetch("beq");
    push_decode("beq");
    o = mk(S_BRANCH, 1'b0);
    o.alua = 1'b1; o.alub = SEL_B; o.aluop = ALU_SUB; o.pcsrc = PC_ALUOUT; o.pcwc = 1'b1;
    push(o, z ? "beq_z1.BRANCH" : "beq_z0.BRANCH");
    drain();
  endtask

  task automatic run_j();
    obs_t o;
    bus.opcode = OP_J;
    push_fetch("j");
    push_decode("j");
    o = mk(S_JUMP, 1'b0);
    o.pcsrc = PC_JUMP; o.pcw = 1'b1;
    push(o, "j.JUMP");
    drain();
  endtask

  initial begin
    obs_t o;
    bus.opcode = 6'h00;
    bus.funct  = 6'h00;
    bus.zero   = 1'b0;
    reset      = 1'b0;

    repeat (3) begin
      @(negedge clk);
      chk(sample(), mk(S_RESET, 1'b0), "reset_hold");
    end
    reset = 1'b1;
    #1 chk(sample(), mk(S_RESET, 1'b0), "reset_release");

    run_r(F_SUB, ALU_SUB, "r_sub");
    run_r(F_ADD, ALU_ADD, "r_add");
    run_r(F_AND, ALU_AND, "r_and");
    run_r(F_OR,  ALU_OR,  "r_or");
    run_r(F_SLT, ALU_SLT, "r_slt");
    run_addi();
    run_lw();
    run_sw(MW + 1);
    run_beq(1'b1);
    run_beq(1'b0);
    run_j();

    bus.opcode = 6'h3F;
    push_fetch("ill");
    push_decode("ill");
    for (int i = 0; i < 20; i++) push(mk(S_HALT, 1'b1), "ill.HALT");
    drain();

    reset = 1'b0;
    #1 chk(sample(), mk(S_RESET, 1'b0), "halt_reset");
    @(negedge clk);
    reset = 1'b1;
    #1 chk(sample(), mk(S_RESET, 1'b0), "halt_release");
    run_addi();

    run_sw(1);
    #2 reset = 1'b0;
    #1 chk(sample(), mk(S_RESET, 1'b0), "abort_sw");
    @(negedge clk);
    chk(sample(), mk(S_RESET, 1'b0), "abort_hold");
    reset = 1'b1;
    #1 chk(sample(), mk(S_RESET, 1'b0), "abort_release");
    run_lw();

    @(negedge clk);
    o = mk(S_FETCH, 1'b0);
    o.alub = SEL_4;
    chk(sample(), o, "final_fetch");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
